// File: rtl/manquehuito_pkg.sv
// Shared types and constants for the PC/branch unit: condition codes, FSM states
// and bit positions inside the {Z, N, C, V} flag vector.
package manquehuito_pkg;

  typedef enum logic [2:0] {
    JMP = 3'b000,
    JEQ = 3'b001,
    JNE = 3'b010,
    JGT = 3'b011,
    JGE = 3'b100,
    JLT = 3'b101,
    JLE = 3'b110,
    JCS = 3'b111
  } jmp_cond_e;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } pcb_state_e;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/branch_cond.sv
// Pure combinational evaluation of a jump condition against a {Z, N, C, V} flag set
// produced by a subtraction a-b.
module branch_cond
  import manquehuito_pkg::*;
(
  input  jmp_cond_e  cond,
  input  logic [3:0] flags,
  output logic       taken
);

  logic z;
  logic n;
  logic c;
  logic v;
  logic lt;

  assign z  = flags[FLAG_Z];
  assign n  = flags[FLAG_N];
  assign c  = flags[FLAG_C];
  assign v  = flags[FLAG_V];
  // Signed less-than after a-b is N xor V (sign corrected for overflow).
  assign lt = n ^ v;

  always_comb begin
    taken = 1'b0;
    case (cond)
      JMP:     taken = 1'b1;
      JEQ:     taken = z;
      JNE:     taken = ~z;
      JGT:     taken = ~z & ~lt;
      JGE:     taken = ~lt;
      JLT:     taken = lt;
      JLE:     taken = z | lt;
      JCS:     taken = c;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_branch_unit.sv
// Program counter with status register, forwarded conditional-jump resolution and
// a one-instruction wrong-path squash after every taken jump.
module pc_branch_unit
  import manquehuito_pkg::*;
#(
  parameter int                  PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                stall_i,
  input  logic                flags_we_i,
  input  logic [3:0]          zncv_i,
  input  logic                jmp_valid_i,
  input  logic [2:0]          jmp_cond_i,
  input  logic [PC_WIDTH-1:0] jmp_target_i,
  output logic [PC_WIDTH-1:0] pc_o,
  output logic [3:0]          zncv_o,
  output logic                taken_o,
  output logic                flush_o
);

  pcb_state_e          state_reg;
  pcb_state_e          state_next;
  logic [PC_WIDTH-1:0] pc_reg;
  logic [PC_WIDTH-1:0] pc_next;
  logic [3:0]          zncv_reg;
  logic [3:0]          zncv_next;
  logic                flush_reg;
  logic [3:0]          eff_flags;
  logic                cond_true;
  logic                taken;

  // Same-cycle flag write is forwarded so a compare can be followed directly by a jump.
  assign eff_flags = flags_we_i ? zncv_i : zncv_reg;

  branch_cond u_branch_cond (
    .cond  (jmp_cond_e'(jmp_cond_i)),
    .flags (eff_flags),
    .taken (cond_true)
  );

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    zncv_next  = zncv_reg;
    taken      = 1'b0;
    case (state_reg)
      RUN: begin
        // The flag producer has already executed, so a stall does not block its write.
        if (flags_we_i) begin
          zncv_next = zncv_i;
        end
        if (!stall_i) begin
          if (jmp_valid_i && cond_true) begin
            taken      = 1'b1;
            pc_next    = jmp_target_i;
            state_next = FLUSH;
          end else begin
            pc_next = pc_reg + PC_WIDTH'(1);
          end
        end
      end
      FLUSH: begin
        if (!stall_i) begin
          pc_next    = pc_reg + PC_WIDTH'(1);
          state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase
    if (rst_i) begin
      taken = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= RUN;
      pc_reg    <= RESET_PC;
      zncv_reg  <= 4'b0000;
      flush_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      zncv_reg  <= zncv_next;
      flush_reg <= (state_next == FLUSH);
    end
  end

  assign pc_o    = pc_reg;
  assign zncv_o  = zncv_reg;
  assign flush_o = flush_reg;
  assign taken_o = taken;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed and randomized bench for pc_branch_unit against a cycle-level behavioural model.
module tb_pc_branch_unit;

  localparam int PC_WIDTH = 8;

  logic                clk_i = 1'b0;
  logic                rst_i = 1'b0;
  logic                stall_i = 1'b0;
  logic                flags_we_i = 1'b0;
  logic [3:0]          zncv_i = 4'b0;
  logic                jmp_valid_i = 1'b0;
  logic [2:0]          jmp_cond_i = 3'b0;
  logic [PC_WIDTH-1:0] jmp_target_i = '0;
  logic [PC_WIDTH-1:0] pc_o;
  logic [3:0]          zncv_o;
  logic                taken_o;
  logic                flush_o;

  int checks = 0;
  int errors = 0;

  // Model state: fetch address, stored flags, and whether the next instruction is squashed.
  int   m_pc = 0;
  logic [3:0] m_z = 4'b0;
  bit   m_fl = 1'b0;

  logic tk;

  always #5 clk_i = ~clk_i;

  pc_branch_unit #(.PC_WIDTH(PC_WIDTH), .RESET_PC(8'h00)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .stall_i      (stall_i),
    .flags_we_i   (flags_we_i),
    .zncv_i       (zncv_i),
    .jmp_valid_i  (jmp_valid_i),
    .jmp_cond_i   (jmp_cond_i),
    .jmp_target_i (jmp_target_i),
    .pc_o         (pc_o),
    .zncv_o       (zncv_o),
    .taken_o      (taken_o),
    .flush_o      (flush_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Condition table in terms of the a-b relation the flags describe.
  function automatic bit cond_ok(input int code, input logic [3:0] f);
    bit eq;
    bit signed_lt;
    eq        = f[3];
    signed_lt = (f[2] != f[0]);
    case (code)
      0: return 1'b1;
      1: return eq;
      2: return !eq;
      3: return !eq && !signed_lt;
      4: return !signed_lt;
      5: return signed_lt;
      6: return eq || signed_lt;
      default: return f[1] == 1'b1;
    endcase
  endfunction

  task automatic cycle(input bit rst, input bit stall, input bit we, input logic [3:0] zin,
                       input bit jv, input logic [2:0] cnd, input logic [7:0] tgt,
                       output logic taken_seen);
    bit exp_t;
    @(negedge clk_i);
    rst_i        = rst;
    stall_i      = stall;
    flags_we_i   = we;
    zncv_i       = zin;
    jmp_valid_i  = jv;
    jmp_cond_i   = cnd;
    jmp_target_i = tgt;
    #1;
    exp_t = !rst && !m_fl && !stall && jv && cond_ok(int'(cnd), we ? zin : m_z);
    taken_seen = taken_o;
    check("taken", {31'b0, taken_o}, {31'b0, exp_t});
    @(posedge clk_i);
    if (rst) begin
      m_pc = 0;
      m_z  = 4'b0;
      m_fl = 1'b0;
    end else if (m_fl) begin
      if (!stall) begin
        m_pc = (m_pc + 1) % 256;
        m_fl = 1'b0;
      end
    end else begin
      if (we) m_z = zin;
      if (!stall) begin
        m_pc = exp_t ? int'(tgt) : (m_pc + 1) % 256;
        m_fl = exp_t;
      end
    end
    #1;
    check("pc", {24'b0, pc_o}, m_pc);
    check("zncv", {28'b0, zncv_o}, {28'b0, m_z});
    check("flush", {31'b0, flush_o}, {31'b0, m_fl});
    $display("t=%0t rst=%0b stl=%0b we=%0b zin=%b jv=%0b c=%0d tgt=%02h | tk=%0b pc=%02h zncv=%b fl=%0b",
             $time, rst, stall, we, zin, jv, cnd, tgt, taken_seen, pc_o, zncv_o, flush_o);
  endtask

  task automatic idle(output logic taken_seen);
    cycle(1'b0, 1'b0, 1'b0, 4'b0, 1'b0, 3'd0, 8'h00, taken_seen);
  endtask

  initial begin
    // Reset and free-running count.
    cycle(1'b1, 1'b1, 1'b1, 4'b1111, 1'b1, 3'd0, 8'h55, tk);
    check("rst_pc", {24'b0, pc_o}, 32'h0);
    check("rst_flush", {31'b0, flush_o}, 32'h0);
    for (int i = 0; i < 3; i++) idle(tk);
    check("count_pc3", {24'b0, pc_o}, 32'h3);
    check("count_zncv", {28'b0, zncv_o}, 32'h0);

    // Wrap-around: preload 0xFE with a jump.
    cycle(1'b0, 1'b0, 1'b0, 4'b0, 1'b1, 3'd0, 8'hFE, tk);
    idle(tk);
    check("wrap_ff", {24'b0, pc_o}, 32'hFF);
    idle(tk);
    check("wrap_00", {24'b0, pc_o}, 32'h00);

    // Forwarded JEQ.
    cycle(1'b0, 1'b0, 1'b1, 4'b1000, 1'b1, 3'd1, 8'h40, tk);
    check("fwd_taken", {31'b0, tk}, 32'h1);
    check("fwd_pc", {24'b0, pc_o}, 32'h40);
    check("fwd_flush", {31'b0, flush_o}, 32'h1);
    check("fwd_zncv", {28'b0, zncv_o}, 32'h8);
    idle(tk);

    // Wrong-path squash: flags and jump in the shadow slot are dropped.
    cycle(1'b0, 1'b0, 1'b1, 4'b0010, 1'b0, 3'd0, 8'h00, tk);
    cycle(1'b0, 1'b0, 1'b0, 4'b0, 1'b1, 3'd0, 8'h10, tk);
    check("sq_pc10", {24'b0, pc_o}, 32'h10);
    cycle(1'b0, 1'b0, 1'b1, 4'b1111, 1'b1, 3'd0, 8'h80, tk);
    check("sq_taken", {31'b0, tk}, 32'h0);
    check("sq_pc11", {24'b0, pc_o}, 32'h11);
    check("sq_zncv", {28'b0, zncv_o}, 32'h2);

    // Spot check: N=1, V=1, Z=0.
    cycle(1'b0, 1'b0, 1'b1, 4'b0101, 1'b0, 3'd0, 8'h00, tk);
    cycle(1'b0, 1'b0, 1'b0, 4'b0, 1'b1, 3'd5, 8'h33, tk);
    check("spot_jlt", {31'b0, tk}, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 4'b0, 1'b1, 3'd3, 8'h33, tk);
    check("spot_jgt", {31'b0, tk}, 32'h1);
    idle(tk);

    // Full sweep of stored flags against every condition.
    for (int f = 0; f < 16; f++) begin
      cycle(1'b0, 1'b0, 1'b1, 4'(f), 1'b0, 3'd0, 8'h00, tk);
      for (int c = 0; c < 8; c++) begin
        cycle(1'b0, 1'b0, 1'b0, 4'b0, 1'b1, 3'(c), 8'($urandom), tk);
        idle(tk);
      end
    end

    // Stall in RUN: PC frozen, flags still written.
    cycle(1'b0, 1'b1, 1'b1, 4'b0100, 1'b1, 3'd0, 8'h20, tk);
    check("stall_taken", {31'b0, tk}, 32'h0);
    cycle(1'b0, 1'b1, 1'b1, 4'b0100, 1'b1, 3'd0, 8'h20, tk);
    check("stall_zncv", {28'b0, zncv_o}, 32'h4);
    // Stall during FLUSH stretches flush_o.
    cycle(1'b0, 1'b0, 1'b0, 4'b0, 1'b1, 3'd0, 8'h60, tk);
    cycle(1'b0, 1'b1, 1'b0, 4'b0, 1'b0, 3'd0, 8'h00, tk);
    cycle(1'b0, 1'b1, 1'b0, 4'b0, 1'b0, 3'd0, 8'h00, tk);
    check("stall_fl_flush", {31'b0, flush_o}, 32'h1);
    check("stall_fl_pc", {24'b0, pc_o}, 32'h60);
    idle(tk);
    check("stall_fl_exit", {24'b0, pc_o}, 32'h61);

    // Reset while in FLUSH.
    cycle(1'b0, 1'b0, 1'b1, 4'b1010, 1'b1, 3'd0, 8'h77, tk);
    cycle(1'b1, 1'b0, 1'b0, 4'b0, 1'b0, 3'd0, 8'h00, tk);
    check("rstfl_pc", {24'b0, pc_o}, 32'h0);
    check("rstfl_flush", {31'b0, flush_o}, 32'h0);
    check("rstfl_zncv", {28'b0, zncv_o}, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) == 0), 1'($urandom),
            4'($urandom), ($urandom_range(0, 2) != 0), 3'($urandom), 8'($urandom), tk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_branch_unit.md
# pc_branch_unit

Program-counter and branch-resolution unit for the 8-bit core; the consumer end of the ALU's result/flag interface. Captures the Z/N/C/V flags produced by the ALU's compare path into a status register, evaluates conditional-jump instructions against them (with same-cycle forwarding), and drives the instruction-fetch address. A taken jump redirects the PC and squashes one wrong-path instruction through a two-state FSM.

## Interface
- `PC_WIDTH`, 8: width of the program counter and jump target.
- `RESET_PC`, 0: PC value loaded on reset.

- `clk_i`: input, 1 bit. Single clock; all state updates on the rising edge.
- `rst_i`: input, 1 bit. Reset, synchronous and active-high.
- `stall_i`: input, 1 bit. Freezes the PC and FSM; jumps are not evaluated.
- `flags_we_i`: input, 1 bit. Write enable for the status register.
- `zncv_i`: input, 4 bits. Flags from the ALU, ordered {Z, N, C, V}.
- `jmp_valid_i`: input, 1 bit. The current instruction is a jump.
- `jmp_cond_i`: input, 3 bits. Jump condition code.
- `jmp_target_i`: input, `PC_WIDTH` bits. Absolute jump target.
- `pc_o`: output, `PC_WIDTH` bits. Registered fetch address.
- `zncv_o`: output, 4 bits. Registered status register.
- `taken_o`: output, 1 bit. Combinational; the jump evaluated this cycle is taken.
- `flush_o`: output, 1 bit. Registered; high while in FLUSH, so the fetched instruction is discarded.

## Operation
- Condition codes: flags come from a−b; `eff` is the effective flag set.
  - 000 JMP: always taken.
  - 001 JEQ: Z.
  - 010 JNE: !Z.
  - 011 JGT: !Z && (N==V).
  - 100 JGE: N==V.
  - 101 JLT: N!=V.
  - 110 JLE: Z || (N!=V).
  - 111 JCS: C.
- Forwarding: `eff` is `zncv_i` when `flags_we_i` is high in the same cycle, otherwise `zncv_o`.
- FSM states are RUN and FLUSH.
- RUN, `stall_i` low:
  - `taken_o` = `jmp_valid_i` && cond(`eff`).
  - If taken: `pc_o` <= `jmp_target_i` and the FSM moves to FLUSH.
  - Otherwise: `pc_o` <= `pc_o` + 1.
  - If `flags_we_i` is high: `zncv_o` <= `zncv_i`.
- RUN, `stall_i` high:
  - `pc_o` and the FSM hold.
  - `taken_o` = 0.
  - Flags are still written when `flags_we_i` is high, since the producing instruction has already executed.
- FLUSH, `stall_i` low:
  - `jmp_valid_i` and `flags_we_i` are ignored (wrong path).
  - `taken_o` = 0.
  - `pc_o` <= `pc_o` + 1.
  - The FSM returns to RUN.
- FLUSH, `stall_i` high: the FSM stays in FLUSH, `pc_o` holds, and inputs are ignored.
- PC arithmetic is modulo 2^`PC_WIDTH`: 0xFF + 1 = 0x00 at the default width. A jump target needs no range check.
- A jump to the current PC is legal: the PC is reloaded and FLUSH is still entered.

## Timing
- Reset values: `pc_o` = `RESET_PC`, `zncv_o` = 4'b0000, FSM = RUN, `flush_o` = 0, `taken_o` = 0.
- `rst_i` has priority over `stall_i` and every other input. Reset asserted mid-FLUSH returns the unit to RUN on the next edge with no residual flush.
- Branch latency:
  - `taken_o` asserts in the evaluation cycle N.
  - `pc_o` = target and `flush_o` = 1 in cycle N+1.
  - `pc_o` = target+1 and `flush_o` = 0 in cycle N+2, provided there is no stall.
- Flag write to visible `zncv_o`: 1 cycle. Forwarding gives jumps zero-cycle visibility.
- Every output except `taken_o` is driven directly from flops.

## Structure
- `manquehuito_pkg` holds:
  - `jmp_cond_e`, a 3-bit enum with the codes above.
  - `pcb_state_e`, with RUN and FLUSH.
  - Named flag-index constants `FLAG_Z` = 3, `FLAG_N` = 2, `FLAG_C` = 1, `FLAG_V` = 0.
- One combinational sub-module, `branch_cond`, takes `jmp_cond_e` and a 4-bit flag set and returns a 1-bit taken. It is unit-testable on its own.

## Test plan
- Reset, then 3 cycles with no jumps: `pc_o` = 0, 1, 2, 3 and `zncv_o` = 0000. With `PC_WIDTH`=8 and the PC preloaded to 0xFE via a jump, the sequence continues …, 0xFF, 0x00.
- Forwarding: `flags_we_i`=1, `zncv_i`=1000, JEQ to 0x40 in the same cycle → `taken_o`=1; next cycle `pc_o`=0x40, `flush_o`=1, `zncv_o`=1000.
- Wrong-path squash: a taken JMP to 0x10, with the next cycle presenting JMP to 0x80 and `flags_we_i`=1, `zncv_i`=1111 → `pc_o`=0x10 then 0x11, and `zncv_o` is unchanged.
- Signed compare sweep: for each of the 16 flag values, stored and then tested with all 8 conditions, `taken_o` matches the condition table exactly. Spot check: N=1, V=1, Z=0 → JGT taken, JLT not taken.
- Stall: `stall_i`=1 for 2 cycles with JMP to 0x20 and `flags_we_i`=1, `zncv_i`=0100 → `pc_o` frozen, `taken_o`=0, `zncv_o`=0100. A stall during FLUSH extends `flush_o` for the same number of cycles.
- Reset in FLUSH: `rst_i` asserted in the cycle after a taken jump → next cycle `pc_o`=`RESET_PC`, `flush_o`=0, `zncv_o`=0000.
